// File: rtl/alu_seq_master_pkg.sv
// Shared ALU command encodings and sequencer state type for the ALU self-test master,
// the ALU itself and any bench driving either of them.
package alu_seq_master_pkg;

    localparam int DEF_W = 32;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Only the arithmetic commands have a golden value; OP_RSV results are stored unchecked.
    function automatic logic op_checked(input logic [1:0] cmd);
        return (cmd == OP_ADD) || (cmd == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_seq_master_if.sv
// Command/result link between the self-test master and the ALU.
// Handshake: the master presents alu_a/alu_b/alu_cmd for exactly one cycle (alu_cmd != OP_NOP)
// only after sampling alu_ready=1; the ALU answers with a one-cycle alu_valid pulse carrying
// alu_result. alu_cmd == OP_NOP means no request on that cycle.
interface alu_seq_master_if #(
    parameter int W = 32
);
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_cmd;
    logic [W-1:0] alu_result;
    logic         alu_valid;
    logic         alu_ready;

    modport master (
        output alu_a, alu_b, alu_cmd,
        input  alu_result, alu_valid, alu_ready
    );

    modport slave (
        input  alu_a, alu_b, alu_cmd,
        output alu_result, alu_valid, alu_ready
    );
endinterface

// File: rtl/alu_seq_master_vec_ram.sv
// Simple DEPTH x DW memory with one write port and one registered read port.
// Contents are never reset so stored vectors and results survive a block reset.
module alu_seq_master_vec_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 66
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/alu_seq_master.sv
// ALU self-test initiator: replays a table of operand/command vectors into the ALU, stores each
// result, and counts results that disagree with the add/sub golden model.
module alu_seq_master
    import alu_seq_master_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [W-1:0]     cfg_a,
    input  logic [W-1:0]     cfg_b,
    input  logic [1:0]       cfg_cmd,
    input  logic [AW:0]      n_vec,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [15:0]      err_cnt,
    input  logic [AW-1:0]    rd_addr,
    output logic [W-1:0]     rd_result,
    alu_seq_master_if.master alu_bus,
    output state_e           dbg_state
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int VW = 2 * W + 2;

    state_e        r_state, w_state_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic [AW:0]   r_nvec, w_nvec_nxt;
    logic [CW-1:0] r_wcnt, w_wcnt_nxt, w_wcnt_inc;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic [15:0]   r_err_cnt, w_err_cnt_nxt;
    logic [W-1:0]  r_alu_a, w_alu_a_nxt;
    logic [W-1:0]  r_alu_b, w_alu_b_nxt;
    logic [1:0]    r_alu_cmd, w_alu_cmd_nxt;
    logic [W-1:0]  r_exp, w_exp_nxt;
    logic          r_chk, w_chk_nxt;
    logic          w_last;
    logic          w_vec_we, w_res_we;
    logic [W-1:0]  w_res_wdata;
    logic [VW-1:0] w_vec_wdata, w_vec_rdata;
    logic [1:0]    w_v_cmd;
    logic [W-1:0]  w_v_a, w_v_b;

    assign w_vec_wdata = {cfg_cmd, cfg_a, cfg_b};
    assign w_v_cmd     = w_vec_rdata[VW-1 -: 2];
    assign w_v_a       = w_vec_rdata[2*W-1 -: W];
    assign w_v_b       = w_vec_rdata[W-1:0];
    assign w_last      = ({1'b0, r_idx} + (AW + 1)'(1)) == r_nvec;
    assign w_wcnt_inc  = r_wcnt + CW'(1);

    // Read address follows the next index so vec[idx] is already on the read port in ISSUE.
    alu_seq_master_vec_ram #(.DEPTH(DEPTH), .AW(AW), .DW(VW)) u_vec_ram (
        .clk     (clk),
        .i_we    (w_vec_we & reset),
        .i_waddr (cfg_addr),
        .i_wdata (w_vec_wdata),
        .i_raddr (w_idx_nxt),
        .o_rdata (w_vec_rdata)
    );

    alu_seq_master_vec_ram #(.DEPTH(DEPTH), .AW(AW), .DW(W)) u_res_ram (
        .clk     (clk),
        .i_we    (w_res_we & reset),
        .i_waddr (r_idx),
        .i_wdata (w_res_wdata),
        .i_raddr (rd_addr),
        .o_rdata (rd_result)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_nvec_nxt    = r_nvec;
        w_wcnt_nxt    = r_wcnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_timeout_nxt = r_timeout;
        w_err_cnt_nxt = r_err_cnt;
        w_alu_a_nxt   = r_alu_a;
        w_alu_b_nxt   = r_alu_b;
        w_alu_cmd_nxt = OP_NOP;
        w_exp_nxt     = r_exp;
        w_chk_nxt     = r_chk;
        w_vec_we      = 1'b0;
        w_res_we      = 1'b0;
        w_res_wdata   = '0;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_vec_we = cfg_we;
                if (start) begin
                    w_nvec_nxt    = n_vec;
                    w_err_cnt_nxt = '0;
                    w_timeout_nxt = 1'b0;
                    w_idx_nxt     = '0;
                    w_wcnt_nxt    = '0;
                    if (n_vec == '0) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_busy_nxt  = 1'b1;
                        w_done_nxt  = 1'b0;
                    end
                end
            end

            S_ISSUE: begin
                if (w_v_cmd == OP_NOP) begin
                    // NOP vectors skip the ALU entirely and record a zero result.
                    w_res_we = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + AW'(1);
                    end
                end else if (alu_bus.alu_ready) begin
                    w_alu_cmd_nxt = w_v_cmd;
                    w_alu_a_nxt   = w_v_a;
                    w_alu_b_nxt   = w_v_b;
                    w_exp_nxt     = (w_v_cmd == OP_SUB) ? (w_v_a - w_v_b) : (w_v_a + w_v_b);
                    w_chk_nxt     = op_checked(w_v_cmd);
                    w_wcnt_nxt    = '0;
                    w_state_nxt   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (alu_bus.alu_valid) begin
                    w_res_we    = 1'b1;
                    w_res_wdata = alu_bus.alu_result;
                    w_wcnt_nxt  = '0;
                    if (r_chk && (alu_bus.alu_result != r_exp) && (r_err_cnt != 16'hFFFF)) begin
                        w_err_cnt_nxt = r_err_cnt + 16'd1;
                    end
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + AW'(1);
                        w_state_nxt = S_ISSUE;
                    end
                end else if (w_wcnt_inc == CW'(TIMEOUT)) begin
                    w_wcnt_nxt    = '0;
                    w_timeout_nxt = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_wcnt_nxt = w_wcnt_inc;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_nvec    <= '0;
            r_wcnt    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_err_cnt <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_cmd <= OP_NOP;
            r_exp     <= '0;
            r_chk     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_nvec    <= w_nvec_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_alu_a   <= w_alu_a_nxt;
            r_alu_b   <= w_alu_b_nxt;
            r_alu_cmd <= w_alu_cmd_nxt;
            r_exp     <= w_exp_nxt;
            r_chk     <= w_chk_nxt;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign timeout         = r_timeout;
    assign err_cnt         = r_err_cnt;
    assign alu_bus.alu_a   = r_alu_a;
    assign alu_bus.alu_b   = r_alu_b;
    assign alu_bus.alu_cmd = r_alu_cmd;
    assign dbg_state       = r_state;
endmodule

// File: tb/tb_alu_seq_master.sv
// Bench for alu_seq_master: a behavioural ALU responder plus a result/err_cnt reference model.
module tb_alu_seq_master;
    import alu_seq_master_pkg::*;

    localparam int W       = 32;
    localparam int DEPTH   = 32;
    localparam int AW      = 5;
    localparam int TIMEOUT = 255;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [W-1:0]  cfg_a = '0;
    logic [W-1:0]  cfg_b = '0;
    logic [1:0]    cfg_cmd = '0;
    logic [AW:0]   n_vec = '0;
    logic          start = 1'b0;
    logic          busy, done, timeout;
    logic [15:0]   err_cnt;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_result;
    state_e        dbg_state;

    alu_seq_master_if #(.W(W)) alu_bus ();

    alu_seq_master #(.W(W), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_a     (cfg_a),
        .cfg_b     (cfg_b),
        .cfg_cmd   (cfg_cmd),
        .n_vec     (n_vec),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .err_cnt   (err_cnt),
        .rd_addr   (rd_addr),
        .rd_result (rd_result),
        .alu_bus   (alu_bus.master),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];
    logic [1:0]   m_cmd [DEPTH];
    logic [W-1:0] m_a   [DEPTH];
    logic [W-1:0] m_b   [DEPTH];
    logic [W-1:0] m_res [DEPTH];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural ALU responder ----------------
    logic         alu_never = 1'b0;
    logic         rdy_rand = 1'b0;
    int           alu_lat = 3;
    int           corrupt_ord = -1;
    logic [W-1:0] corrupt_val = '0;
    int           issue_cnt = 0;
    int           first_issue_cyc = 0;
    int           wait_cycles = 0;
    int           pend = 0;
    logic [W-1:0] pend_val = '0;

    function automatic logic [W-1:0] alu_fn(input logic [1:0] cmd, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (cmd)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_RSV:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    initial begin
        alu_bus.alu_valid  = 1'b0;
        alu_bus.alu_ready  = 1'b1;
        alu_bus.alu_result = '0;
    end

    always @(negedge clk) begin
        alu_bus.alu_valid = 1'b0;
        if (rdy_rand) alu_bus.alu_ready = 1'($urandom_range(0, 1));
        if (dbg_state == S_WAIT) wait_cycles++;
        if (alu_bus.alu_cmd != OP_NOP) begin
            if (issue_cnt == 0) first_issue_cyc = cyc;
            pend_val = (issue_cnt == corrupt_ord) ? corrupt_val
                                                  : alu_fn(alu_bus.alu_cmd, alu_bus.alu_a, alu_bus.alu_b);
            pend = alu_never ? 0 : alu_lat;
            issue_cnt++;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                alu_bus.alu_valid  = 1'b1;
                alu_bus.alu_result = pend_val;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_vec(input int addr, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] cmd);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_a = a; cfg_b = b; cfg_cmd = cmd;
        @(negedge clk);
        cfg_we = 1'b0;
        m_a[addr] = a; m_b[addr] = b; m_cmd[addr] = cmd;
    endtask

    task automatic start_run(input int n);
        @(negedge clk);
        issue_cnt = 0;
        wait_cycles = 0;
        n_vec = (AW + 1)'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val(tag, 64'(ok), 64'd1);
    endtask

    task automatic read_res(input int addr, output logic [W-1:0] v);
        @(negedge clk);
        rd_addr = AW'(addr);
        @(negedge clk);
        v = rd_result;
    endtask

    // Reference: each vector's stored value is 0 for NOP, otherwise whatever the ALU returned;
    // a mismatch is counted for ADD/SUB when that value differs from a+b / a-b.
    task automatic check_run(input int n, input string tag);
        int ord;
        int errs;
        logic [W-1:0] r;
        logic [W-1:0] got;
        ord = 0;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (m_cmd[i] == OP_NOP) begin
                r = '0;
            end else begin
                r = (ord == corrupt_ord) ? corrupt_val : alu_fn(m_cmd[i], m_a[i], m_b[i]);
                if (m_cmd[i] == OP_ADD && r != m_a[i] + m_b[i]) errs++;
                if (m_cmd[i] == OP_SUB && r != m_a[i] - m_b[i]) errs++;
                ord++;
            end
            m_res[i] = r;
            exp_q.push_back(r);
        end
        check_val({tag, "_done"}, 64'(done), 64'd1);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_timeout"}, 64'(timeout), 64'd0);
        check_val({tag, "_err_cnt"}, 64'(err_cnt), 64'(errs));
        check_val({tag, "_issues"}, 64'(issue_cnt), 64'(ord));
        for (int i = 0; i < n; i++) begin
            read_res(i, got);
            check_val($sformatf("%s_res%0d", tag, i), 64'(got), 64'(exp_q.pop_front()));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int rise_cyc;
        logic [W-1:0] got;

        // Reset held with start asserted.
        reset = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_timeout", 64'(timeout), 64'd0);
        check_val("rst_alu_cmd", 64'(alu_bus.alu_cmd), 64'(OP_NOP));
        check_val("rst_err_cnt", 64'(err_cnt), 64'd0);
        check_val("rst_state", 64'(dbg_state), 64'(S_IDLE));
        start = 1'b0;
        reset = 1'b1;

        // Two ADDs including a wrap.
        write_vec(0, 32'h0000_0001, 32'h0000_0002, OP_ADD);
        write_vec(1, 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD);
        start_run(2);
        wait_done(100, "add2_wait");
        check_run(2, "add2");
        check_val("add2_res0_const", 64'(m_res[0]), 64'd3);
        check_val("add2_res1_const", 64'(m_res[1]), 64'd0);

        // Corrupted result on vector 0.
        write_vec(0, 32'h2, 32'h2, OP_ADD);
        write_vec(1, 32'h7, 32'h5, OP_SUB);
        write_vec(2, 32'h9, 32'h1, OP_ADD);
        corrupt_ord = 0;
        corrupt_val = 32'h5;
        start_run(3);
        wait_done(100, "mism_wait");
        check_run(3, "mism");
        check_val("mism_err_const", 64'(err_cnt), 64'd1);
        corrupt_ord = -1;

        // Backpressure with a leading NOP vector.
        write_vec(0, $urandom, $urandom, OP_NOP);
        write_vec(1, 32'd10, 32'd3, OP_SUB);
        alu_bus.alu_ready = 1'b0;
        start_run(2);
        repeat (10) @(negedge clk);
        check_val("bp_no_issue", 64'(issue_cnt), 64'd0);
        check_val("bp_alu_cmd", 64'(alu_bus.alu_cmd), 64'(OP_NOP));
        alu_bus.alu_ready = 1'b1;
        rise_cyc = cyc;
        wait_done(100, "bp_wait");
        check_val("bp_issue_cyc", 64'(first_issue_cyc), 64'(rise_cyc + 1));
        check_run(2, "bp");

        // Lost result.
        alu_never = 1'b1;
        write_vec(0, 32'd5, 32'd6, OP_ADD);
        start_run(1);
        wait_done(TIMEOUT + 50, "to_wait");
        check_val("to_timeout", 64'(timeout), 64'd1);
        check_val("to_done", 64'(done), 64'd1);
        check_val("to_busy", 64'(busy), 64'd0);
        check_val("to_wait_cycles", 64'(wait_cycles), 64'(TIMEOUT));
        read_res(0, got);
        check_val("to_res_kept", 64'(got), 64'(m_res[0]));
        alu_never = 1'b0;

        // Empty run.
        start_run(0);
        check_val("n0_done", 64'(done), 64'd1);
        check_val("n0_busy", 64'(busy), 64'd0);
        check_val("n0_timeout", 64'(timeout), 64'd0);
        check_val("n0_issues", 64'(issue_cnt), 64'd0);

        // start and cfg_we while busy are ignored.
        write_vec(0, $urandom, $urandom, OP_ADD);
        write_vec(1, $urandom, $urandom, OP_SUB);
        write_vec(2, $urandom, $urandom, OP_RSV);
        write_vec(3, $urandom, $urandom, OP_ADD);
        alu_lat = 5;
        start_run(4);
        start = 1'b1; n_vec = 1;
        cfg_we = 1'b1; cfg_addr = 3; cfg_a = $urandom; cfg_b = $urandom; cfg_cmd = OP_SUB;
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        wait_done(200, "busy_wait");
        check_run(4, "busy");

        // Randomised runs with random ready and latency.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                write_vec(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
            end
            alu_lat = $urandom_range(1, 4);
            corrupt_ord = (r % 2 == 0) ? int'($urandom_range(0, 3)) : -1;
            corrupt_val = $urandom;
            rdy_rand = 1'b1;
            start_run(n);
            wait_done(3000, $sformatf("rnd%0d_wait", r));
            rdy_rand = 1'b0;
            @(negedge clk);
            alu_bus.alu_ready = 1'b1;
            check_run(n, $sformatf("rnd%0d", r));
        end
        corrupt_ord = -1;
        alu_lat = 3;

        // Reset while waiting for a result.
        alu_never = 1'b1;
        write_vec(0, 32'd11, 32'd4, OP_SUB);
        start_run(1);
        repeat (5) @(negedge clk);
        check_val("rw_in_wait", 64'(dbg_state), 64'(S_WAIT));
        reset = 1'b0;
        @(negedge clk);
        check_val("rw_state", 64'(dbg_state), 64'(S_IDLE));
        check_val("rw_busy", 64'(busy), 64'd0);
        check_val("rw_alu_cmd", 64'(alu_bus.alu_cmd), 64'(OP_NOP));
        reset = 1'b1;
        alu_never = 1'b0;
        start_run(1);
        wait_done(100, "rw_rerun_wait");
        check_run(1, "rw_rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_seq_master.md
Name: alu_seq_master

Overview:
- Synthesizable initiator for the ALU command/result handshake (i_a/i_b/i_cmd in; o_result/o_valid/o_ready out).
- Holds a table of operand/command vectors loaded over a simple write port.
- On start, issues each vector to the ALU, waits for the result, stores it, and checks it against an internal golden model.
- Replaces simulation-only stimulus so ALU self-test can run on hardware; sits between a host/config bus and the ALU instance.

Parameters:
- W, 32, operand/result width.
- DEPTH, 32, number of vector/result entries.
- AW, 5, address width, equal to log2(DEPTH).
- TIMEOUT, 255, maximum cycles in WAIT for alu_valid before aborting.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low; reset==0 at a rising clk edge resets the block.
- cfg_we  in  1  write vector entry.
- cfg_addr  in  AW  vector index to write.
- cfg_a  in  W  operand A.
- cfg_b  in  W  operand B.
- cfg_cmd  in  2  ALU command (OP_*).
- n_vec  in  AW+1  number of vectors to run; sampled on start.
- start  in  1  single-cycle run request.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start.
- timeout  out  1  run aborted on a lost result.
- err_cnt  out  16  mismatch count, saturating.
- rd_addr  in  AW  result read index.
- rd_result  out  W  stored result; 1-cycle read latency.
- alu_a  out  W  to ALU i_a.
- alu_b  out  W  to ALU i_b.
- alu_cmd  out  2  to ALU i_cmd.
- alu_result  in  W  from ALU o_result.
- alu_valid  in  1  from ALU o_valid.
- alu_ready  in  1  from ALU o_ready.

Behaviour:
- Reset:
  - State IDLE; alu_cmd=OP_NOP; alu_a=alu_b=0.
  - busy=0, done=0, timeout=0, err_cnt=0, idx=0, wait counter=0.
  - Vector and result memories are not cleared.
  - Reset mid-run returns to IDLE on that edge, and alu_cmd is NOP on the next cycle.
- All outputs are registered. FSM states: IDLE, ISSUE, WAIT, DONE.
- cfg_we:
  - Honoured only in IDLE or DONE.
  - Ignored while busy=1.
- start in IDLE or DONE:
  - Latches n_vec; clears err_cnt, done and timeout; sets idx=0 and busy=1.
  - Goes to ISSUE.
  - If n_vec==0, goes straight to DONE (done=1 one cycle after start).
- start while busy is ignored.
- ISSUE:
  - alu_cmd=OP_NOP until alu_ready=1 is sampled.
  - Then drives alu_a/alu_b/alu_cmd from vec[idx] for exactly one cycle and latches the expected value. Next state is WAIT.
  - If vec[idx].cmd==OP_NOP, nothing is issued: result 0 is stored, there is no check, and the block advances in one cycle.
- WAIT:
  - alu_cmd=OP_NOP.
  - The wait counter increments each cycle.
  - On alu_valid=1:
    - Store alu_result into res[idx].
    - If checked and alu_result differs from expected, err_cnt increments, saturating at 0xFFFF.
    - If idx==n_vec-1, go to DONE; otherwise idx++ and go to ISSUE. The wait counter resets.
  - If the counter reaches TIMEOUT with no valid: timeout=1 and go to DONE; res[idx] is left unchanged.
- Golden model, modulo 2^W:
  - OP_ADD gives a+b.
  - OP_SUB gives a-b.
  - OP_RSV (2'b11) is issued and stored but not checked.
- alu_valid outside WAIT is ignored.
- Valid and timeout in the same cycle: valid wins.
- DONE: busy=0, done=1, all held until the next start.
- rd_result = res[rd_addr] registered; readable in any state.

Decomposition:
- Shared header/package alu_defs:
  - OP_NOP=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_RSV=2'b11.
  - Default W=32.
  - Shared by the ALU, this block and benches.
- One sub-module, alu_vec_ram:
  - Parameterized DEPTH×width RAM with 1 write port and 1 registered read port.
  - Instantiated twice: vectors (W+W+2 bits) and results (W bits).

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 -> busy=0, done=0, alu_cmd=OP_NOP, err_cnt=0.
- Two ADDs: load {0x00000001+0x00000002, 0xFFFFFFFF+0x00000001}, n_vec=2, start, correct ALU model (ready, 3-cycle latency).
  - Result: res=3 and 0 (wrap), err_cnt=0, done=1.
  - Each vector issued with alu_cmd=OP_ADD for exactly one cycle.
- Mismatch: ALU model returns 0x5 for 0x2+0x2 on vector 0 of 3 -> err_cnt=1, rd_result(0)=0x5, done=1.
- Backpressure and NOP:
  - Keep alu_ready=0 for 10 cycles -> alu_cmd stays NOP; issue occurs the cycle after ready rises.
  - A NOP vector gives res=0 with no issue.
- Timeout: ALU never asserts valid, TIMEOUT=255 -> timeout=1 and done=1 after 255 WAIT cycles; busy=0.
- Corner cases:
  - n_vec=0 with start -> done=1 next cycle, no issue.
  - start during a run -> ignored.
  - reset=0 in WAIT -> IDLE on the next edge.
